// File: rtl/pr_hrav_dispatcher_pkg.sv
// Shared types for the HRAV packet dispatcher: FSM states, TUSER route codes
// and the resolved per-packet target.
package pr_hrav_dispatcher_pkg;

  localparam int TUSER_W = 128;
  localparam int CNT_W   = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FWD_C0   = 3'd1,
    ST_FWD_C1   = 3'd2,
    ST_FWD_ICAP = 3'd3,
    ST_DROP     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ROUTE_CORE0 = 2'b00,
    ROUTE_CORE1 = 2'b01,
    ROUTE_ICAP  = 2'b10,
    ROUTE_ANY   = 2'b11
  } route_t;

  typedef enum logic [1:0] {
    TGT_CORE0 = 2'd0,
    TGT_CORE1 = 2'd1,
    TGT_ICAP  = 2'd2,
    TGT_DROP  = 2'd3
  } target_t;

  function automatic state_t fwd_state(target_t t);
    state_t s;
    case (t)
      TGT_CORE0: s = ST_FWD_C0;
      TGT_CORE1: s = ST_FWD_C1;
      TGT_ICAP:  s = ST_FWD_ICAP;
      default:   s = ST_DROP;
    endcase
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pr_hrav_dispatcher_if.sv
// AXI4-Stream link used for the DMA input and each dispatcher output port.
interface pr_hrav_dispatcher_if #(
  parameter int DATA_WIDTH = 256
) ();
  import pr_hrav_dispatcher_pkg::*;

  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [TUSER_W-1:0]      tuser;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);

endinterface

// File: rtl/pr_hrav_dispatcher_route.sv
// SOP route decode: maps the TUSER route code, core enables and the
// load-balance pointer to a target port.
module pr_hrav_dispatcher_route
  import pr_hrav_dispatcher_pkg::*;
(
  input  route_t  code,
  input  logic    core_0_enb,
  input  logic    core_1_enb,
  input  logic    rr_ptr,
  output target_t target,
  output logic    rr_advance
);

  logic pref_enb;
  logic other_enb;

  assign pref_enb  = rr_ptr ? core_1_enb : core_0_enb;
  assign other_enb = rr_ptr ? core_0_enb : core_1_enb;

  // NOTE: every output gets a default first so no path through the block
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    target     = TGT_DROP;
    rr_advance = 1'b0;
    case (code)
      ROUTE_CORE0: target = core_0_enb ? TGT_CORE0 : TGT_DROP;
      ROUTE_CORE1: target = core_1_enb ? TGT_CORE1 : TGT_DROP;
      ROUTE_ICAP:  target = TGT_ICAP;
      default: begin
        if (pref_enb) begin
          target     = rr_ptr ? TGT_CORE1 : TGT_CORE0;
          rr_advance = 1'b1;
        end else if (other_enb) begin
          target     = rr_ptr ? TGT_CORE0 : TGT_CORE1;
          rr_advance = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/pr_hrav_dispatcher.sv
// HRAV dispatcher: steers DMA packets to scanner core 0/1 or ICAP with
// zero-latency SOP routing, round-robin balancing and drop accounting.
module pr_hrav_dispatcher
  import pr_hrav_dispatcher_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH = 256,
  parameter int C_M_AXIS_DATA_WIDTH = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  core_0_enb,
  input  logic                  core_1_enb,
  pr_hrav_dispatcher_if.slave   s_axis,
  pr_hrav_dispatcher_if.master  core0_m_axis,
  pr_hrav_dispatcher_if.master  core1_m_axis,
  pr_hrav_dispatcher_if.master  icap_m_axis,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic                  rr_ptr
);

  if (C_S_AXIS_DATA_WIDTH != C_M_AXIS_DATA_WIDTH) begin : g_width_check
    $error("pr_hrav_dispatcher: input and output stream widths must match");
  end

  state_t  state;
  target_t sop_target;
  target_t sel;
  logic    sop_rr_advance;
  logic    core_lost;
  logic    s_ready;
  logic    hs;

  pr_hrav_dispatcher_route u_route (
    .code       (route_t'(s_axis.tuser[1:0])),
    .core_0_enb (core_0_enb),
    .core_1_enb (core_1_enb),
    .rr_ptr     (rr_ptr),
    .target     (sop_target),
    .rr_advance (sop_rr_advance)
  );

  // A core losing its enable mid-packet diverts the rest to the drop sink
  // in the same cycle, so no beat reaches a core under reconfiguration.
  always_comb begin
    sel       = TGT_DROP;
    core_lost = 1'b0;
    case (state)
      ST_IDLE:     sel = sop_target;
      ST_FWD_C0: begin
        core_lost = !core_0_enb;
        sel       = core_0_enb ? TGT_CORE0 : TGT_DROP;
      end
      ST_FWD_C1: begin
        core_lost = !core_1_enb;
        sel       = core_1_enb ? TGT_CORE1 : TGT_DROP;
      end
      ST_FWD_ICAP: sel = TGT_ICAP;
      default:     sel = TGT_DROP;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    if (ARESETN) begin
      case (sel)
        TGT_CORE0: s_ready = core0_m_axis.tready;
        TGT_CORE1: s_ready = core1_m_axis.tready;
        TGT_ICAP:  s_ready = icap_m_axis.tready;
        default:   s_ready = 1'b1;
      endcase
    end
  end

  assign s_axis.tready = s_ready;
  assign hs            = s_axis.tvalid && s_ready;

  // Payload is broadcast; only TVALID is steered.
  assign core0_m_axis.tdata  = s_axis.tdata;
  assign core0_m_axis.tstrb  = s_axis.tstrb;
  assign core0_m_axis.tuser  = s_axis.tuser;
  assign core0_m_axis.tlast  = s_axis.tlast;
  assign core0_m_axis.tvalid = ARESETN && s_axis.tvalid && (sel == TGT_CORE0);

  assign core1_m_axis.tdata  = s_axis.tdata;
  assign core1_m_axis.tstrb  = s_axis.tstrb;
  assign core1_m_axis.tuser  = s_axis.tuser;
  assign core1_m_axis.tlast  = s_axis.tlast;
  assign core1_m_axis.tvalid = ARESETN && s_axis.tvalid && (sel == TGT_CORE1);

  assign icap_m_axis.tdata   = s_axis.tdata;
  assign icap_m_axis.tstrb   = s_axis.tstrb;
  assign icap_m_axis.tuser   = s_axis.tuser;
  assign icap_m_axis.tlast   = s_axis.tlast;
  assign icap_m_axis.tvalid  = ARESETN && s_axis.tvalid && (sel == TGT_ICAP);

  // NOTE: state is updated with non-blocking assignments and the reset is
  // sampled on the clock edge, so every register sees pre-edge values.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state    <= ST_IDLE;
      rr_ptr   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hs) begin
            if (sel == TGT_DROP) drop_cnt <= sat_inc(drop_cnt);
            if (sop_rr_advance)  rr_ptr   <= ~rr_ptr;
            if (!s_axis.tlast)   state    <= fwd_state(sel);
          end
        end
        ST_FWD_C0, ST_FWD_C1: begin
          if (core_lost) begin
            drop_cnt <= sat_inc(drop_cnt);
            state    <= (hs && s_axis.tlast) ? ST_IDLE : ST_DROP;
          end else if (hs && s_axis.tlast) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          if (hs && s_axis.tlast) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pr_hrav_dispatcher.sv
// Self-checking bench for pr_hrav_dispatcher: directed scenarios followed by
// randomized traffic, checked every cycle against a packet-level model.
module tb_pr_hrav_dispatcher;
  import pr_hrav_dispatcher_pkg::*;

  localparam int W = 256;

  logic clk = 1'b0;
  logic rst_n;
  logic en0, en1;
  logic [31:0] drop_cnt;
  logic rr_ptr;

  always #5 clk = ~clk;

  pr_hrav_dispatcher_if #(.DATA_WIDTH(W)) s_if ();
  pr_hrav_dispatcher_if #(.DATA_WIDTH(W)) c0_if ();
  pr_hrav_dispatcher_if #(.DATA_WIDTH(W)) c1_if ();
  pr_hrav_dispatcher_if #(.DATA_WIDTH(W)) ic_if ();

  pr_hrav_dispatcher #(
    .C_S_AXIS_DATA_WIDTH (W),
    .C_M_AXIS_DATA_WIDTH (W)
  ) dut (
    .ACLK         (clk),
    .ARESETN      (rst_n),
    .core_0_enb   (en0),
    .core_1_enb   (en1),
    .s_axis       (s_if),
    .core0_m_axis (c0_if),
    .core1_m_axis (c1_if),
    .icap_m_axis  (ic_if),
    .drop_cnt     (drop_cnt),
    .rr_ptr       (rr_ptr)
  );

  int tests = 0;
  int fails = 0;

  // Packet-level reference: which destination owns the packet in flight
  // (0 core0, 1 core1, 2 icap, 3 discard), plus pointer and drop tally.
  bit          m_busy = 1'b0;
  int          m_dest = 0;
  bit          m_rr   = 1'b0;
  logic [31:0] m_drops = '0;

  bit          last_hs;
  bit          last_ready;
  bit          rand_ready = 1'b0;
  bit          rand_en    = 1'b0;
  logic [W-1:0] cur_data;
  int          beats [3];
  int          lasts [3];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit core_en(int c);
    return (c == 0) ? en0 : en1;
  endfunction

  function automatic bit port_ready(int p);
    case (p)
      0:       return c0_if.tready;
      1:       return c1_if.tready;
      default: return ic_if.tready;
    endcase
  endfunction

  function automatic logic [W-1:0] port_data(int p);
    case (p)
      0:       return c0_if.tdata;
      1:       return c1_if.tdata;
      default: return ic_if.tdata;
    endcase
  endfunction

  function automatic logic port_last(int p);
    case (p)
      0:       return c0_if.tlast;
      1:       return c1_if.tlast;
      default: return ic_if.tlast;
    endcase
  endfunction

  function automatic int sop_dest(int code);
    int pref;
    case (code)
      0:       return en0 ? 0 : 3;
      1:       return en1 ? 1 : 3;
      2:       return 2;
      default: begin
        pref = m_rr ? 1 : 0;
        if (core_en(pref))     return pref;
        if (core_en(1 - pref)) return 1 - pref;
        return 3;
      end
    endcase
  endfunction

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) begin
      beats[i] = 0;
      lasts[i] = 0;
    end
  endtask

  // One clock: randomize environment, check at negedge, advance model at posedge.
  task automatic cycle();
    int       d;
    bit       lost;
    bit       exp_ready;
    bit [2:0] exp_valid;
    logic [2:0] obs_valid;
    if (rand_ready) begin
      c0_if.tready = 1'($urandom_range(0, 1));
      c1_if.tready = 1'($urandom_range(0, 1));
      ic_if.tready = 1'($urandom_range(0, 1));
    end
    if (rand_en && $urandom_range(0, 19) == 0) begin
      en0 = 1'($urandom_range(0, 1));
      en1 = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    lost = 1'b0;
    if (m_busy) begin
      d = m_dest;
      if (d < 2 && !core_en(d)) begin
        d    = 3;
        lost = 1'b1;
      end
    end else begin
      d = sop_dest(int'(s_if.tuser[1:0]));
    end
    exp_valid = 3'b000;
    exp_ready = 1'b0;
    if (rst_n) begin
      if (d < 3) exp_valid[d] = s_if.tvalid;
      exp_ready = (d == 3) ? 1'b1 : port_ready(d);
    end
    obs_valid = {ic_if.tvalid, c1_if.tvalid, c0_if.tvalid};
    check("s_tready", s_if.tready, exp_ready);
    check("m_tvalid", obs_valid, exp_valid);
    check("rr_ptr", rr_ptr, m_rr);
    check("drop_cnt", drop_cnt, m_drops);
    if (rst_n && d < 3 && s_if.tvalid) begin
      check("m_tdata", port_data(d), cur_data);
      check("m_tlast", port_last(d), s_if.tlast);
    end
    last_ready = s_if.tready;
    last_hs    = rst_n && s_if.tvalid && exp_ready;
    if (last_hs && d < 3) begin
      beats[d]++;
      if (s_if.tlast) lasts[d]++;
    end
    @(posedge clk);
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_rr    = 1'b0;
      m_drops = '0;
    end else if (!m_busy) begin
      if (last_hs) begin
        if (d == 3) m_drops++;
        if (s_if.tuser[1:0] == 2'b11 && d < 2) m_rr = !m_rr;
        if (!s_if.tlast) begin
          m_busy = 1'b1;
          m_dest = d;
        end
      end
    end else begin
      if (lost) begin
        m_drops++;
        m_dest = 3;
      end
      if (last_hs && s_if.tlast) m_busy = 1'b0;
    end
    #1;
  endtask

  task automatic present_beat(input logic [1:0] code, input bit last);
    for (int i = 0; i < W / 32; i++) cur_data[i*32 +: 32] = $urandom();
    s_if.tdata = cur_data;
    s_if.tstrb = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
    s_if.tstrb = s_if.tstrb;
    s_if.tuser = {$urandom(), $urandom(), $urandom(), $urandom()};
    s_if.tuser[1:0] = code;
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
  endtask

  task automatic wait_hs();
    int budget = 300;
    do begin
      cycle();
      budget--;
    end while (!last_hs && budget > 0);
    check("beat_timeout", last_hs, 1'b1);
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_beat(input logic [1:0] code, input bit last, input int gap);
    s_if.tvalid = 1'b0;
    repeat (gap) cycle();
    present_beat(code, last);
    wait_hs();
  endtask

  task automatic send_pkt(input logic [1:0] code, input int len, input int gap);
    for (int i = 0; i < len; i++)
      send_beat((i == 0) ? code : 2'($urandom_range(0, 3)), i == len - 1, gap);
  endtask

  initial begin
    int stall_lo;
    rst_n        = 1'b0;
    en0          = 1'b1;
    en1          = 1'b1;
    c0_if.tready = 1'b1;
    c1_if.tready = 1'b1;
    ic_if.tready = 1'b1;
    present_beat(2'b00, 1'b0);
    @(posedge clk);
    #1;
    // Reset held with a valid beat present: everything must stay quiet.
    repeat (2) cycle();
    s_if.tvalid = 1'b0;
    rst_n = 1'b1;
    cycle();

    // 3-beat packet to core 0.
    clear_counts();
    send_pkt(2'b00, 3, 0);
    cycle();
    check("r028_c0_beats", beats[0], 3);
    check("r028_c0_last", lasts[0], 1);
    check("r028_other_beats", beats[1] + beats[2], 0);
    check("r028_drop", drop_cnt, 0);

    // Round-robin over four single-beat ANY packets.
    clear_counts();
    for (int i = 0; i < 4; i++) send_pkt(2'b11, 1, 0);
    cycle();
    check("r029_c0_beats", beats[0], 2);
    check("r029_c1_beats", beats[1], 2);
    check("r029_rr", rr_ptr, 1'b0);

    // ANY with core0 disabled goes to core1; core1 packet with core1 off drops.
    clear_counts();
    en0 = 1'b0;
    send_pkt(2'b11, 1, 0);
    cycle();
    check("r030_any_c1", beats[1], 1);
    check("r030_rr", rr_ptr, 1'b1);
    en0 = 1'b1;
    en1 = 1'b0;
    present_beat(2'b01, 1'b1);
    wait_hs();
    check("r030_drop_ready", last_ready, 1'b1);
    check("r030_no_valid", beats[0] + beats[1] + beats[2], 1);
    cycle();
    check("r030_drop_cnt", drop_cnt, 1);
    en1 = 1'b1;

    // Core1 loses its enable after two beats of a 5-beat packet.
    clear_counts();
    send_beat(2'b01, 1'b0, 0);
    send_beat(2'b10, 1'b0, 0);
    en1 = 1'b0;
    send_beat(2'b00, 1'b0, 0);
    send_beat(2'b00, 1'b0, 1);
    send_beat(2'b00, 1'b1, 0);
    check("r031_c1_beats", beats[1], 2);
    check("r031_c1_last", lasts[1], 0);
    cycle();
    check("r031_drop_cnt", drop_cnt, 2);
    en1 = 1'b1;
    send_pkt(2'b01, 2, 0);
    check("r031_next_beats", beats[1], 4);
    check("r031_next_last", lasts[1], 1);

    // ICAP back-pressure stalls the whole stream.
    clear_counts();
    send_beat(2'b10, 1'b0, 0);
    ic_if.tready = 1'b0;
    present_beat(2'b00, 1'b0);
    stall_lo = 0;
    repeat (10) begin
      cycle();
      if (!last_ready) stall_lo++;
    end
    check("r032_stall_cycles", stall_lo, 10);
    check("r032_no_core0", beats[0], 0);
    ic_if.tready = 1'b1;
    wait_hs();
    send_beat(2'b00, 1'b1, 0);
    check("r032_icap_last", lasts[2], 1);
    send_pkt(2'b00, 1, 0);
    check("r032_core0_after", beats[0], 1);

    // Reset during beat 2 of a core0 packet; the held beat becomes an SOP.
    clear_counts();
    send_beat(2'b00, 1'b0, 0);
    present_beat(2'b01, 1'b1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    wait_hs();
    check("r033_c1_sop", beats[1], 1);
    check("r033_c0_beats", beats[0], 1);
    cycle();
    check("r033_drop", drop_cnt, 0);

    // Randomized traffic with fluctuating back-pressure and enables.
    rand_ready = 1'b1;
    rand_en    = 1'b1;
    for (int p = 0; p < 250; p++)
      send_pkt(2'($urandom_range(0, 3)), $urandom_range(1, 4), $urandom_range(0, 2));
    rand_en    = 1'b0;
    rand_ready = 1'b0;
    en0 = 1'b1;
    en1 = 1'b1;
    c0_if.tready = 1'b1;
    c1_if.tready = 1'b1;
    ic_if.tready = 1'b1;
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pr_hrav_dispatcher.md
PR_HRAV_DISPATCHER -- requirements
Module: pr_hrav_dispatcher

Interface
REQ-001 Parameter C_S_AXIS_DATA_WIDTH, default 256: width of the DMA input stream data.
REQ-002 Parameter C_M_AXIS_DATA_WIDTH, default 256: width of every output stream; it SHALL equal C_S_AXIS_DATA_WIDTH.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 ACLK  in  1  clock.
REQ-005 ARESETN  in  1  synchronous active-low reset.
REQ-006 core_0_enb, core_1_enb  in  1 each  scanner-core enable; low means decoupled for reconfiguration.
REQ-007 S_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  in  W/W/8/128/1/1  packets from the RX DMA (software); S_AXIS_TREADY  out  1.
REQ-008 CORE0_M_AXIS_*, CORE1_M_AXIS_*, ICAP_M_AXIS_*  TDATA/TSTRB/TUSER/TVALID/TLAST out (W, W/8, 128, 1, 1); TREADY in  1.
REQ-009 drop_cnt  out  32  count of packets discarded.
REQ-010 rr_ptr  out  1  current scanner load-balance pointer (debug).

Function
REQ-011 Routing SHALL be decided on the first beat (SOP) from S_AXIS_TUSER[1:0]: 00 core0, 01 core1, 10 ICAP, 11 any scanner.
REQ-012 Code 11 SHALL select core rr_ptr if that core is enabled, else the other core if enabled, else drop.
REQ-013 rr_ptr SHALL toggle only on acceptance of an SOP beat routed by code 11 to a core.
REQ-014 Packets for a disabled core (00 with core_0_enb=0, 01 with core_1_enb=0) SHALL be dropped.
REQ-015 FSM states IDLE, FWD_C0, FWD_C1, FWD_ICAP, DROP; the state SHALL lock routing until the TLAST beat handshakes.
REQ-016 IDLE: the SOP beat SHALL be passed combinationally (zero latency) to the selected port; on a handshake with TLAST=0 go to FWD_x or DROP; with TLAST=1 stay in IDLE.
REQ-017 FWD_x: only port x SHALL see TVALID=S_AXIS_TVALID; S_AXIS_TREADY=x TREADY; on handshake with TLAST=1 go to IDLE.
REQ-018 All non-selected output TVALIDs SHALL be 0; TDATA/TSTRB/TUSER/TLAST MAY be broadcast to all ports.
REQ-019 DROP: S_AXIS_TREADY=1, all output TVALID=0; on a TLAST beat go to IDLE.
REQ-020 If the target core enable falls in FWD_C0/FWD_C1, the remaining beats SHALL be dropped (go to DROP the same cycle, output TVALID gated 0), and the packet SHALL count as dropped.
REQ-021 drop_cnt SHALL increment by 1 per dropped packet (on SOP decision or on the REQ-020 transition), never twice per packet, and saturate at 0xFFFFFFFF.
REQ-022 ICAP routing SHALL ignore both enables.
REQ-023 Output TVALID SHALL never depend on output TREADY.

Reset
REQ-024 On ARESETN=0 at a clock edge: state=IDLE, rr_ptr=0, drop_cnt=0; all output TVALID=0 and S_AXIS_TREADY=0 while reset is held.
REQ-025 Reset mid-packet SHALL abandon the packet; the first beat after reset SHALL be treated as SOP.

Structure
REQ-026 State encodings and TUSER route codes (ROUTE_CORE0/CORE1/ICAP/ANY) SHALL live in the shared pr_hrav package.
REQ-027 The FSM, round-robin pointer and drop counter SHALL stay in one module; the output register slice pr_hrav_dbuf MAY be instantiated per output port for timing, adding 1 cycle of latency.

Verification
REQ-028 3-beat packet, TUSER[1:0]=00, both enables high -> 3 beats on CORE0 only, TLAST on beat 3, drop_cnt=0.
REQ-029 Four 1-beat packets with code 11, both enabled -> cores 0,1,0,1 in order; rr_ptr ends 0.
REQ-030 Code 11 with core_0_enb=0, rr_ptr=0 -> routed to core1, rr_ptr toggles to 1; code 01 with core_1_enb=0 -> TREADY=1, no output TVALID, drop_cnt=1.
REQ-031 5-beat packet to core1 with core_1_enb dropped after beat 2 -> CORE1 sees 2 beats without TLAST, beats 3-5 absorbed, drop_cnt+1, next packet routed normally.
REQ-032 ICAP TREADY held low for 10 cycles mid-packet while a code-00 packet waits -> S_AXIS_TREADY=0, no CORE0 TVALID until the ICAP TLAST handshakes.
REQ-033 ARESETN pulsed low during beat 2 of a core0 packet -> state IDLE, drop_cnt=0; the next beat is decoded as SOP by its TUSER.
